// File: rtl/byte_merger.sv
// byte_merger: packs a valid/ready byte stream into NBYTES-wide words, first byte in the MSB lane.
// A one-entry output register decouples the consumer; flush emits a PAD-filled partial word.
module byte_merger #(
  parameter int          NBYTES   = 4,
  parameter logic [7:0]  PAD_BYTE = 8'h00,
  localparam int         CW       = $clog2(NBYTES) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_byte,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_word,
  output logic [CW-1:0]         out_count,
  output logic [CW-2:0]         fill
);

  localparam logic [CW-2:0]       LAST     = (CW-1)'(NBYTES - 1);
  localparam logic [8*NBYTES-1:0] PAD_WORD = {NBYTES{PAD_BYTE}};

  logic [CW-2:0]       cnt;
  logic [CW-2:0]       cnt_after;
  logic [8*NBYTES-1:0] acc;
  logic [8*NBYTES-1:0] acc_merged;
  logic                flush_pend;
  logic                pend_next;
  logic                slot_free;
  logic                at_last;
  logic                accept;
  logic                word_done;
  logic                flush_emit;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // in_ready depends combinationally on out_ready so a full output slot can drain and
  // refill in the same cycle.
  always_comb begin
    slot_free  = !out_valid || out_ready;
    at_last    = (cnt == LAST);
    in_ready   = !flush_pend && (!at_last || slot_free);
    accept     = in_valid && in_ready;
    word_done  = accept && at_last;
    cnt_after  = cnt;
    acc_merged = acc;
    if (accept) begin
      acc_merged[8*(NBYTES-1-int'(cnt)) +: 8] = in_byte;
      cnt_after = at_last ? '0 : cnt + (CW-1)'(1);
    end
    // A flush only matters if bytes remain once this cycle's byte is counted.
    pend_next  = flush_pend || (flush && (cnt_after != '0));
    flush_emit = pend_next && slot_free;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      acc        <= PAD_WORD;
      out_valid  <= 1'b0;
      out_word   <= '0;
      out_count  <= '0;
      flush_pend <= 1'b0;
    end else if (word_done) begin
      out_word   <= acc_merged;
      out_count  <= CW'(NBYTES);
      out_valid  <= 1'b1;
      cnt        <= '0;
      acc        <= PAD_WORD;
      flush_pend <= 1'b0;
    end else if (flush_emit) begin
      out_word   <= acc_merged;
      out_count  <= {1'b0, cnt_after};
      out_valid  <= 1'b1;
      cnt        <= '0;
      acc        <= PAD_WORD;
      flush_pend <= 1'b0;
    end else begin
      cnt        <= cnt_after;
      acc        <= acc_merged;
      flush_pend <= pend_next;
      if (out_ready) out_valid <= 1'b0;
    end
  end

  assign fill = cnt;

endmodule
